// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one single-port BRAM between instruction fetch and
//            load/store, serialising accesses and returning done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
  parameter int ADDR_W        = 7,
  parameter int DATA_W        = 32,
  parameter int READ_LAT      = 1,
  parameter int MAX_DM_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch requester
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_kill,
  output logic              o_if_done,
  output logic [DATA_W-1:0] o_if_rdata,
  // load/store requester
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_done,
  output logic [DATA_W-1:0] o_dm_rdata,
  // BRAM port
  output logic              o_mem_clk,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  localparam int c_cnt_w    = 2;
  localparam int c_streak_w = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);

  localparam logic [c_cnt_w-1:0]    c_cnt_init   = c_cnt_w'(READ_LAT - 1);
  localparam logic [c_cnt_w-1:0]    c_cnt_one    = c_cnt_w'(1);
  localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_DM_STREAK);
  localparam logic [c_streak_w-1:0] c_streak_one = c_streak_w'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_owner_dm;
  logic                r_kill;
  logic [c_streak_w-1:0] r_streak;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_if_done;
  logic                r_dm_done;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;

  state_t              w_state_nxt;
  logic                w_owner_dm_nxt;
  logic                w_kill_nxt;
  logic [c_streak_w-1:0] w_streak_nxt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic                w_mem_en_nxt;
  logic                w_mem_we_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [DATA_W-1:0]   w_mem_wdata_nxt;
  logic                w_if_done_nxt;
  logic                w_dm_done_nxt;
  logic [DATA_W-1:0]   w_if_rdata_nxt;
  logic [DATA_W-1:0]   w_dm_rdata_nxt;
  logic                w_dm_wins;
  logic                w_kill_now;

  // DM has priority until it has won MAX_DM_STREAK contested grants in a row.
  assign w_dm_wins  = i_dm_req && !(i_if_req && (r_streak == c_streak_max));
  // Kill seen this cycle or earlier in the current fetch transaction.
  assign w_kill_now = r_kill | (i_if_kill & ~r_owner_dm & (r_state != S_IDLE));

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_dm_nxt  = r_owner_dm;
    w_kill_nxt      = r_kill;
    w_streak_nxt    = r_streak;
    w_cnt_nxt       = r_cnt;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_done_nxt   = 1'b0;
    w_dm_done_nxt   = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_dm_rdata_nxt  = r_dm_rdata;

    case (r_state)
      S_IDLE: begin
        if (i_if_req || i_dm_req) begin
          w_state_nxt    = S_ISSUE;
          w_mem_en_nxt   = 1'b1;
          w_kill_nxt     = 1'b0;
          w_owner_dm_nxt = w_dm_wins;
          if (w_dm_wins) begin
            w_mem_we_nxt    = i_dm_we;
            w_mem_addr_nxt  = i_dm_addr;
            w_mem_wdata_nxt = i_dm_wdata;
            if (i_if_req && (r_streak != c_streak_max)) begin
              w_streak_nxt = r_streak + c_streak_one;
            end
          end else begin
            w_mem_addr_nxt = i_if_addr;
            w_streak_nxt   = '0;
          end
        end
      end

      S_ISSUE: begin
        w_kill_nxt = w_kill_now;
        if (r_mem_we) begin
          w_state_nxt   = S_DONE;
          w_dm_done_nxt = r_owner_dm;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = c_cnt_init;
        end
      end

      S_WAIT: begin
        w_kill_nxt = w_kill_now;
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
          if (r_owner_dm) begin
            w_dm_done_nxt  = 1'b1;
            w_dm_rdata_nxt = i_mem_rdata;
          end else if (!w_kill_now) begin
            w_if_done_nxt  = 1'b1;
            w_if_rdata_nxt = i_mem_rdata;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_cnt_one;
        end
      end

      S_DONE: begin
        w_kill_nxt  = w_kill_now;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_owner_dm  <= 1'b0;
      r_kill      <= 1'b0;
      r_streak    <= '0;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_done   <= 1'b0;
      r_dm_done   <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner_dm  <= w_owner_dm_nxt;
      r_kill      <= w_kill_nxt;
      r_streak    <= w_streak_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_done   <= w_if_done_nxt;
      r_dm_done   <= w_dm_done_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_dm_rdata  <= w_dm_rdata_nxt;
    end
  end

  assign o_mem_clk   = clk;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_done   = r_if_done;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_done   = r_dm_done;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem_arbiter
// Purpose  : Self-checking bench: transaction-level model plus directed cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;
  localparam int AW   = 7;
  localparam int DW   = 32;
  localparam int L    = 1;
  localparam int MAXS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_req = 0, if_kill = 0, dm_req = 0, dm_we = 0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          if_done, dm_done, mem_clk, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, bram_q;
  logic [AW-1:0] mem_addr;

  logic          d3_if_req = 0;
  logic [AW-1:0] d3_if_addr = '0;
  logic          d3_if_done, d3_dm_done, d3_mem_clk, d3_mem_en, d3_mem_we, d3_busy;
  logic [DW-1:0] d3_if_rdata, d3_dm_rdata, d3_mem_wdata, d3_q1, d3_q2, d3_q3;
  logic [AW-1:0] d3_mem_addr;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(L), .MAX_DM_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_kill(if_kill),
    .o_if_done(if_done), .o_if_rdata(if_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_done(dm_done), .o_dm_rdata(dm_rdata),
    .o_mem_clk(mem_clk), .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(bram_q),
    .o_busy(busy));

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3), .MAX_DM_STREAK(MAXS)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(d3_if_req), .i_if_addr(d3_if_addr), .i_if_kill(1'b0),
    .o_if_done(d3_if_done), .o_if_rdata(d3_if_rdata),
    .i_dm_req(1'b0), .i_dm_we(1'b0), .i_dm_addr(7'd0), .i_dm_wdata(32'd0),
    .o_dm_done(d3_dm_done), .o_dm_rdata(d3_dm_rdata),
    .o_mem_clk(d3_mem_clk), .o_mem_en(d3_mem_en), .o_mem_we(d3_mem_we),
    .o_mem_addr(d3_mem_addr), .o_mem_wdata(d3_mem_wdata), .i_mem_rdata(d3_q3),
    .o_busy(d3_busy));

  function automatic logic [31:0] f_init(input int i);
    case (i)
      5:       return 32'hDEADBEEF;
      6:       return 32'hCAFEF00D;
      20:      return 32'h20202020;
      40:      return 32'h40404040;
      default: return 32'h5A000000 ^ (i * 32'h01010101);
    endcase
  endfunction

  // BRAM with one cycle read latency
  logic [DW-1:0] bram [128];
  initial begin
    for (int i = 0; i < 128; i++) bram[i] = f_init(i);
    bram_q = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) bram[mem_addr] <= mem_wdata;
        bram_q <= bram[mem_addr];
      end
    end
  end

  // BRAM with three cycle read latency
  logic [DW-1:0] bram3 [128];
  initial begin
    for (int i = 0; i < 128; i++) bram3[i] = f_init(i);
    d3_q1 = '0; d3_q2 = '0; d3_q3 = '0;
    forever begin
      @(posedge clk);
      if (d3_mem_en) d3_q1 <= bram3[d3_mem_addr];
      d3_q2 <= d3_q1;
      d3_q3 <= d3_q2;
    end
  end

  // Transaction-level model: m_t counts cycles since the grant edge.
  int          m_t = 0, m_streak = 0;
  bit          m_dm = 0, m_we = 0, m_kill = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_data = '0, m_if_rd = '0, m_dm_rd = '0;
  logic [DW-1:0] mmem [128];

  function automatic int m_len(input bit we);
    return we ? 2 : 2 + L;
  endfunction

  initial begin
    bit dm_win;
    for (int i = 0; i < 128; i++) mmem[i] = f_init(i);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_t = 0; m_streak = 0; m_kill = 0; m_we = 0;
        m_if_rd = '0; m_dm_rd = '0;
      end else if (m_t == 0) begin
        if (if_req || dm_req) begin
          dm_win = dm_req && !(if_req && m_streak == MAXS);
          m_dm   = dm_win;
          m_kill = 0;
          m_t    = 1;
          if (dm_win) begin
            m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
            if (if_req && m_streak < MAXS) m_streak++;
          end else begin
            m_we = 0; m_addr = if_addr; m_streak = 0;
          end
          m_data = mmem[m_addr];
          if (m_we) mmem[m_addr] = m_wdata;
        end
      end else begin
        if (!m_dm && if_kill && m_t < m_len(m_we)) m_kill = 1;
        if (m_t == m_len(m_we)) m_t = 0;
        else begin
          m_t++;
          if (m_t == m_len(m_we) && !m_we) begin
            if (m_dm) m_dm_rd = m_data;
            else if (!m_kill) m_if_rd = m_data;
          end
        end
      end
    end
  end

  int n_checks = 0, n_err = 0;
  int n_if_done = 0, n_dm_done = 0;
  bit log_grants = 0;
  bit grant_dm [$];
  logic          last_en_we = 0;
  logic [AW-1:0] last_en_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    chk("busy",     32'(busy),     32'(m_t != 0));
    chk("mem_en",   32'(mem_en),   32'(m_t == 1));
    chk("mem_we",   32'(mem_we),   32'(m_t == 1 && m_we));
    if (m_t == 1) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    if (m_t == 1 && m_we) chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_done",  32'(if_done),  32'(m_t == m_len(m_we) && !m_dm && !m_we && !m_kill));
    chk("dm_done",  32'(dm_done),  32'(m_t == m_len(m_we) && m_dm));
    chk("if_rdata", if_rdata, m_if_rd);
    chk("dm_rdata", dm_rdata, m_dm_rd);
    if (mem_en) begin
      last_en_we = mem_we;
      last_en_addr = mem_addr;
      if (log_grants) grant_dm.push_back(mem_addr == 7'd40);
    end
    if (if_done) n_if_done++;
    if (dm_done) n_dm_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit dm, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(dm ? dm_done : if_done) && cyc < 40);
    if (!(dm ? dm_done : if_done)) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_done timeout dm=%0d", dm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cyc, n0, n_en, n_busy, done_at;
    bit exp_seq [8];
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",     32'(busy),   32'd0);
    chk("rst_mem_en",   32'(mem_en), 32'd0);
    chk("rst_if_rdata", if_rdata,    32'd0);
    chk("rst_d3_busy",  32'(d3_busy), 32'd0);
    rst_n = 1;
    tick(); tick();

    // IF-only read of address 5
    if_addr = 7'd5; if_req = 1;
    wait_done(0, cyc);
    chk("t1_latency", 32'(cyc), 32'd3);
    chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("t1_en_addr", 32'(last_en_addr), 32'd5);
    if_req = 0;
    tick();

    // DM store then load of address 9
    dm_addr = 7'd9; dm_we = 1; dm_wdata = 32'h12345678; dm_req = 1;
    wait_done(1, cyc);
    chk("t2_st_latency", 32'(cyc), 32'd2);
    chk("t2_st_we", 32'(last_en_we), 32'd1);
    chk("t2_st_addr", 32'(last_en_addr), 32'd9);
    dm_req = 0; dm_we = 0;
    tick();
    dm_req = 1;
    wait_done(1, cyc);
    chk("t2_ld_latency", 32'(cyc), 32'd3);
    chk("t2_ld_rdata", dm_rdata, 32'h12345678);
    dm_req = 0;
    tick();

    // Both requesters held: streak limit forces IF every fourth grant
    if_addr = 7'd20; dm_addr = 7'd40; dm_we = 0;
    grant_dm.delete();
    log_grants = 1;
    if_req = 1; dm_req = 1;
    for (int i = 0; i < 80 && grant_dm.size() < 8; i++) tick();
    if_req = 0; dm_req = 0;
    log_grants = 0;
    if (grant_dm.size() < 8) begin
      n_checks++; n_err++;
      $display("FAIL t3_grant_count actual=%0d required=8", grant_dm.size());
    end else begin
      for (int i = 0; i < 8; i++) chk($sformatf("t3_grant%0d", i), 32'(grant_dm[i]), 32'(exp_seq[i]));
    end
    repeat (6) tick();
    chk("t3_if_rdata", if_rdata, 32'h20202020);
    chk("t3_dm_rdata", dm_rdata, 32'h40404040);

    // Fetch killed during WAIT; pending DM load then served
    n0 = n_if_done;
    if_addr = 7'd6; if_req = 1;
    tick();
    dm_addr = 7'd9; dm_we = 0; dm_req = 1;
    tick();
    chk("t4_en_addr", 32'(last_en_addr), 32'd6);
    if_kill = 1; if_req = 0;
    tick();
    if_kill = 0;
    chk("t4_if_done", 32'(if_done), 32'd0);
    wait_done(1, cyc);
    chk("t4_dm_latency", 32'(cyc), 32'd4);
    chk("t4_dm_rdata", dm_rdata, 32'h12345678);
    chk("t4_if_rdata", if_rdata, 32'h20202020);
    chk("t4_if_pulses", 32'(n_if_done - n0), 32'd0);
    dm_req = 0;
    tick();

    // Asynchronous reset during WAIT of a DM load
    dm_addr = 7'd9; dm_req = 1;
    tick(); tick();
    #2 rst_n = 0;
    #1;
    chk("t5_busy",      32'(busy),      32'd0);
    chk("t5_mem_en",    32'(mem_en),    32'd0);
    chk("t5_mem_we",    32'(mem_we),    32'd0);
    chk("t5_mem_addr",  32'(mem_addr),  32'd0);
    chk("t5_mem_wdata", mem_wdata,      32'd0);
    chk("t5_if_done",   32'(if_done),   32'd0);
    chk("t5_dm_done",   32'(dm_done),   32'd0);
    chk("t5_if_rdata",  if_rdata,       32'd0);
    chk("t5_dm_rdata",  dm_rdata,       32'd0);
    dm_req = 0;
    n0 = n_dm_done;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    tick();
    dm_addr = 7'd5; dm_req = 1;
    wait_done(1, cyc);
    chk("t5_latency", 32'(cyc), 32'd3);
    chk("t5_dm_rdata_new", dm_rdata, 32'hDEADBEEF);
    dm_req = 0;
    tick();
    chk("t5_dm_pulses", 32'(n_dm_done - n0), 32'd1);

    // READ_LAT=3 instance: fetch of address 0
    n_en = 0; n_busy = 0; done_at = -1;
    d3_if_addr = 7'd0; d3_if_req = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (d3_mem_en) n_en++;
      if (d3_busy) n_busy++;
      if (d3_if_done && done_at < 0) begin
        done_at = i;
        d3_if_req = 0;
      end
    end
    d3_if_req = 0;
    chk("t6_mem_en_cycles", 32'(n_en), 32'd1);
    chk("t6_busy_cycles", 32'(n_busy), 32'd5);
    chk("t6_done_at", 32'(done_at), 32'd5);
    chk("t6_if_rdata", d3_if_rdata, 32'h5A000000);
    chk("t6_dm_done", 32'(d3_dm_done), 32'd0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
